// File: rtl/corr_toggle_capture_pkg.sv
// Shared types and default widths for the correlation toggle-capture block.
// Holds the FSM state encoding and the packed result record layout.
package corr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    HOLD  = 2'd3
  } corr_state_t;

  localparam int CORR_VEC_W = 4;
  localparam int CORR_CNT_W = 8;
  localparam int CORR_SIM_W = 9;

  // One record per window, tag fields first, then the measured edge activity.
  typedef struct packed {
    logic [CORR_SIM_W-1:0] sim;
    logic                  q;
    logic [CORR_VEC_W-1:0] vec_from;
    logic [CORR_VEC_W-1:0] vec_to;
    logic [CORR_CNT_W-1:0] rise;
    logic [CORR_CNT_W-1:0] fall;
    logic                  fin;
  } corr_res_t;

endpackage

// File: rtl/corr_toggle_capture_if.sv
// Window-start request and result-record handshake bundle for corr_toggle_capture.
// master = sequencer/readout side, slave = the capture block.
interface corr_toggle_capture_if import corr_pkg::*; #(
  parameter int CNT_W = CORR_CNT_W,
  parameter int SIM_W = CORR_SIM_W
);
  logic                  start;
  logic                  q_in;
  logic [CORR_VEC_W-1:0] vec_from;
  logic [CORR_VEC_W-1:0] vec_to;
  logic                  res_valid;
  logic                  res_ready;
  logic [SIM_W-1:0]      res_sim;
  logic                  res_q;
  logic [CORR_VEC_W-1:0] res_from;
  logic [CORR_VEC_W-1:0] res_to;
  logic [CNT_W-1:0]      res_rise;
  logic [CNT_W-1:0]      res_fall;
  logic                  res_final;

  modport master (
    output start, q_in, vec_from, vec_to, res_ready,
    input  res_valid, res_sim, res_q, res_from, res_to, res_rise, res_fall, res_final
  );

  modport slave (
    input  start, q_in, vec_from, vec_to, res_ready,
    output res_valid, res_sim, res_q, res_from, res_to, res_rise, res_fall, res_final
  );
endinterface

// File: rtl/corr_toggle_capture_edge_counter.sv
// Baseline register plus saturating rise/fall counters for one observation window.
// clr wipes the counters, load sets the baseline, en compares and counts.
module corr_edge_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic             y,
  output logic             prev,
  output logic [CNT_W-1:0] rise,
  output logic [CNT_W-1:0] fall
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             prev_r;
  logic [CNT_W-1:0] rise_r;
  logic [CNT_W-1:0] fall_r;

  // Baseline tracking and edge counting; a change of sampled y is an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 1'b0;
      rise_r <= {CNT_W{1'b0}};
      fall_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      rise_r <= {CNT_W{1'b0}};
      fall_r <= {CNT_W{1'b0}};
    end else if (load) begin
      prev_r <= y;
    end else if (en) begin
      prev_r <= y;
      if (y != prev_r) begin
        if (y) begin
          rise_r <= sat_inc(rise_r);
        end else begin
          fall_r <= sat_inc(fall_r);
        end
      end
    end
  end

  assign prev = prev_r;
  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/corr_toggle_capture.sv
// Per-window glitch counter: counts rising/falling edges of y_in and emits a tagged record.
// Define CORR_CAPTURE_SYNC_EN to put a 2-flop synchronizer in front of edge detection.
module corr_toggle_capture import corr_pkg::*; #(
  parameter int CNT_W   = CORR_CNT_W,
  parameter int WIN_CYC = 16,
  parameter int SIM_W   = CORR_SIM_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  y_in,
  corr_toggle_capture_if.slave  bus,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CYC_W = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;

  corr_state_t           state_r;
  corr_state_t           state_nxt_s;
  logic [CYC_W-1:0]      cyc_r;
  logic                  y_samp_r;
  logic                  start_acc_s;
  logic                  arm_s;
  logic                  cnt_en_s;
  logic                  hs_s;
  logic                  ovr_s;
  logic                  last_cyc_s;
  logic                  res_valid_r;
  logic                  busy_r;
  logic                  overrun_r;
  logic [SIM_W-1:0]      sim_r;
  logic                  q_r;
  logic [CORR_VEC_W-1:0] from_r;
  logic [CORR_VEC_W-1:0] to_r;
  logic                  prev_s;
  logic [CNT_W-1:0]      rise_s;
  logic [CNT_W-1:0]      fall_s;

`ifdef CORR_CAPTURE_SYNC_EN
  logic y_meta_r;

  // Two-flop synchronizer for y_in coming from a timed gate-level netlist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_meta_r <= 1'b0;
      y_samp_r <= 1'b0;
    end else begin
      y_meta_r <= y_in;
      y_samp_r <= y_meta_r;
    end
  end
`else
  // Single sampling flop for zero-delay sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_samp_r <= 1'b0;
    end else begin
      y_samp_r <= y_in;
    end
  end
`endif

  assign last_cyc_s = (cyc_r == CYC_W'(WIN_CYC - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = ARM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARM: begin
        state_nxt_s = COUNT;
      end
      COUNT: begin
        if (last_cyc_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = COUNT;
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM output decode into per-cycle control strobes.
  always_comb begin
    start_acc_s = 1'b0;
    arm_s       = 1'b0;
    cnt_en_s    = 1'b0;
    hs_s        = 1'b0;
    ovr_s       = 1'b0;
    case (state_r)
      IDLE: begin
        start_acc_s = bus.start;
      end
      ARM: begin
        arm_s = 1'b1;
        ovr_s = bus.start;
      end
      COUNT: begin
        cnt_en_s = 1'b1;
        ovr_s    = bus.start;
      end
      HOLD: begin
        hs_s  = bus.res_ready;
        ovr_s = bus.start;
      end
      default: begin
        ovr_s = 1'b0;
      end
    endcase
  end

  // COUNT-phase cycle counter; idles at zero outside COUNT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_r <= {CYC_W{1'b0}};
    end else if (cnt_en_s && !last_cyc_s) begin
      cyc_r <= cyc_r + CYC_W'(1);
    end else begin
      cyc_r <= {CYC_W{1'b0}};
    end
  end

  // Window tag capture, index advance and status flags, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r         <= 1'b0;
      from_r      <= {CORR_VEC_W{1'b0}};
      to_r        <= {CORR_VEC_W{1'b0}};
      sim_r       <= {SIM_W{1'b0}};
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (start_acc_s) begin
        q_r    <= bus.q_in;
        from_r <= bus.vec_from;
        to_r   <= bus.vec_to;
      end
      if (hs_s) begin
        sim_r <= sim_r + SIM_W'(1);
      end
      if (ovr_s) begin
        overrun_r <= 1'b1;
      end
      res_valid_r <= (state_nxt_s == HOLD);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  corr_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_acc_s),
    .load  (arm_s),
    .en    (cnt_en_s),
    .y     (y_samp_r),
    .prev  (prev_s),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  assign bus.res_valid = res_valid_r;
  assign bus.res_sim   = sim_r;
  assign bus.res_q     = q_r;
  assign bus.res_from  = from_r;
  assign bus.res_to    = to_r;
  assign bus.res_rise  = rise_s;
  assign bus.res_fall  = fall_s;
  assign bus.res_final = prev_s;
  assign busy          = busy_r;
  assign overrun       = overrun_r;

endmodule

// File: tb/tb_corr_toggle_capture.sv
// Directed bench for corr_toggle_capture: vector table plus back-pressure, reset,
// full index sweep and a narrow-counter saturation instance.
module tb_corr_toggle_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic y_main;
  logic y_sat;
  logic busy_main, ovr_main, busy_sat, ovr_sat;

  corr_toggle_capture_if #(.CNT_W(8), .SIM_W(9)) bm ();
  corr_toggle_capture_if #(.CNT_W(2), .SIM_W(9)) bs ();

  corr_toggle_capture #(.CNT_W(8), .WIN_CYC(16), .SIM_W(9)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .y_in    (y_main),
    .bus     (bm.slave),
    .busy    (busy_main),
    .overrun (ovr_main)
  );

  corr_toggle_capture #(.CNT_W(2), .WIN_CYC(16), .SIM_W(9)) u_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .y_in    (y_sat),
    .bus     (bs.slave),
    .busy    (busy_sat),
    .overrun (ovr_sat)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        q;
    logic [3:0]  vf;
    logic [3:0]  vt;
    logic [16:0] yp;
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic        fin;
  } vec_t;

  vec_t tbl [6];

  logic [8:0] g_sim;
  logic       g_q;
  logic [3:0] g_from, g_to;
  logic [7:0] g_rise, g_fall;
  logic       g_fin;
  int         g_lat;

  // yp[k] is driven on y_main during window cycle k (cycle 0 = start cycle).
  task automatic run_window(input logic q, input logic [3:0] vf, input logic [3:0] vt,
                            input logic [16:0] yp, input bit hs);
    @(negedge clk);
    y_main = yp[0];
    @(negedge clk);
    bm.start = 1'b1; bm.q_in = q; bm.vec_from = vf; bm.vec_to = vt;
    y_main = yp[0];
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      bm.start = 1'b0;
      y_main = yp[k];
    end
    g_lat = 16;
    while (bm.res_valid !== 1'b1 && g_lat < 40) begin
      @(negedge clk);
      g_lat++;
    end
    g_sim = bm.res_sim; g_q = bm.res_q; g_from = bm.res_from; g_to = bm.res_to;
    g_rise = bm.res_rise; g_fall = bm.res_fall; g_fin = bm.res_final;
    if (hs) begin
      bm.res_ready = 1'b1;
      @(negedge clk);
      bm.res_ready = 1'b0;
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic       v17;
    logic [8:0] exp_sim;
    int         hi_cnt;
    int         n;

    tbl[0] = '{1'b1, 4'h3, 4'hC, 17'h1FFE0, 8'd1, 8'd0, 1'b1};
    tbl[1] = '{1'b0, 4'h5, 4'hA, 17'h00CCC, 8'd3, 8'd3, 1'b0};
    tbl[2] = '{1'b1, 4'hF, 4'h0, 17'h1FFFF, 8'd0, 8'd0, 1'b1};
    tbl[3] = '{1'b0, 4'h8, 4'h1, 17'h00007, 8'd0, 8'd1, 1'b0};
    tbl[4] = '{1'b1, 4'h6, 4'h9, 17'h01554, 8'd6, 8'd6, 1'b0};
    tbl[5] = '{1'b0, 4'h2, 4'hD, 17'h1FF0F, 8'd1, 8'd1, 1'b1};

    rst_n = 1'b0; y_main = 1'b0; y_sat = 1'b0;
    bm.start = 1'b0; bm.q_in = 1'b0; bm.vec_from = 4'h0; bm.vec_to = 4'h0; bm.res_ready = 1'b0;
    bs.start = 1'b0; bs.q_in = 1'b0; bs.vec_from = 4'h0; bs.vec_to = 4'h0; bs.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {bm.res_valid, busy_main, ovr_main, bm.res_sim, bm.res_rise,
                        bm.res_fall, bm.res_final, bm.res_from}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_window(tbl[i].q, tbl[i].vf, tbl[i].vt, tbl[i].yp, 1'b1);
      chk("tag", {g_sim, g_q, g_from, g_to}, {9'(i), tbl[i].q, tbl[i].vf, tbl[i].vt});
      chk("rise", 32'(g_rise), 32'(tbl[i].rise));
      chk("fall", 32'(g_fall), 32'(tbl[i].fall));
      chk("final", 32'(g_fin), 32'(tbl[i].fin));
      chk("latency", 32'(g_lat), 32'd18);
    end

    // Back-pressure: record must hold while a stray start is ignored.
    run_window(1'b0, 4'h5, 4'hA, 17'h00000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        bm.start = 1'b1; bm.q_in = 1'b1; bm.vec_from = 4'hF; bm.vec_to = 4'hF;
      end else begin
        bm.start = 1'b0;
      end
      chk("hold_stable", {bm.res_valid, bm.res_q, bm.res_from, bm.res_to, bm.res_sim},
          {1'b1, 1'b0, 4'h5, 4'hA, 9'd6});
    end
    chk("overrun_set", 32'(ovr_main), 32'd1);
    bm.res_ready = 1'b1;
    @(negedge clk);
    bm.res_ready = 1'b0;
    chk("after_hs", {bm.res_valid, busy_main}, 32'h0);
    run_window(1'b1, 4'h1, 4'h2, 17'h00000, 1'b1);
    chk("next_sim", {g_sim, g_from}, {9'd7, 4'h1});

    // Reset in COUNT cycle 5 with one edge already counted.
    @(negedge clk);
    bm.start = 1'b1; bm.q_in = 1'b1; bm.vec_from = 4'h9; bm.vec_to = 4'h6; y_main = 1'b0;
    @(negedge clk);
    bm.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    y_main = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid", {bm.res_valid, busy_main, ovr_main, bm.res_sim, bm.res_rise,
                      bm.res_fall, bm.res_final, bm.res_q, bm.res_from}, 32'h0);
    y_main = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bm.res_valid === 1'b1) hi_cnt++;
    end
    chk("no_record_after_reset", 32'(hi_cnt), 32'd0);

    // Back-to-back windows at the minimum period; index wraps after 511.
    bm.res_ready = 1'b1;
    y_main = 1'b0;
    v17 = 1'b0;
    for (int w = 0; w < 513; w++) begin
      exp_sim = w[8:0];
      @(negedge clk);
      bm.start = 1'b1;
      for (int c = 1; c <= 18; c++) begin
        @(negedge clk);
        bm.start = 1'b0;
        if (c == 17) v17 = bm.res_valid;
        if (c == 18) chk("sweep_rec", {v17, bm.res_valid, bm.res_sim}, {1'b0, 1'b1, exp_sim});
      end
    end
    @(negedge clk);
    bm.res_ready = 1'b0;
    chk("sweep_no_overrun", {ovr_main, busy_main}, 32'h0);

    // Narrow counters: toggling every cycle must saturate at 3.
    @(negedge clk);
    bs.start = 1'b1; bs.q_in = 1'b1; bs.vec_from = 4'hA; bs.vec_to = 4'h5;
    n = 0;
    while (bs.res_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      bs.start = 1'b0;
      y_sat = ~y_sat;
      n++;
    end
    chk("sat_latency", 32'(n), 32'd18);
    chk("sat_counts", {bs.res_rise, bs.res_fall}, {2'd3, 2'd3});
    chk("sat_tag", {bs.res_sim, bs.res_q, bs.res_from, bs.res_to}, {9'd0, 1'b1, 4'hA, 4'h5});
    bs.res_ready = 1'b1;
    @(negedge clk);
    bs.res_ready = 1'b0;
    chk("sat_done", {bs.res_valid, busy_sat, ovr_sat}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
